bus_arb_rr: RTL and testbench

Parametrised bus arbiter and grant FSM for N requesters sharing one bus. It follows the IDLE/BBUSY/BWAIT/BFREE grant protocol and adds round-robin selection, a programmable free (turnaround) interval, and an optional hold-timeout that forcibly revokes a stuck grant. It sits between the requesting masters and the shared bus slave, which returns `done` and `dly`.

---
 rtl/bus_arb_rr_pkg.sv | 24 ++
 rtl/bus_arb_rr_if.sv | 39 +++
 rtl/bus_arb_rr_rr_pick.sv | 42 ++++
 rtl/bus_arb_rr.sv | 134 +++++++++++++
 tb/tb_bus_arb_rr.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_arb_rr_pkg.sv
// Shared types and helpers for the round-robin bus arbiter.
// Holds the grant FSM state encoding and a width helper used for sizing vectors.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BBUSY = 2'd1,
        BWAIT = 2'd2,
        BFREE = 2'd3
    } arb_state_t;

    // Number of bits needed to index 'value' items, never less than one.
    function automatic int clog2_min1(input int value);
        int bits;
        bits = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                bits = i + 1;
            end
        end
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage

// File: rtl/bus_arb_rr_if.sv
// Request/grant bundle between the requesting masters, the bus slave and the arbiter.
// The master modport is the arbiter's view; slave is the view of everything around it.
interface bus_arb_rr_if
    import bus_arb_pkg::*;
#(
    parameter int N_REQ = 4
) ();

    localparam int ID_W = clog2_min1(N_REQ);

    logic [N_REQ-1:0] req;
    logic             done;
    logic             dly;
    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  gnt_id;
    logic             busy;
    logic             timeout;

    modport master (
        input  req,
        input  done,
        input  dly,
        output gnt,
        output gnt_id,
        output busy,
        output timeout
    );

    modport slave (
        output req,
        output done,
        output dly,
        input  gnt,
        input  gnt_id,
        input  busy,
        input  timeout
    );

endinterface

// File: rtl/bus_arb_rr_rr_pick.sv
// Round-robin winner selection: first asserted request at or above i_ptr, wrapping.
// Purely combinational; i_ptr is expected to be below N.
module rr_pick
    import bus_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]                i_req,
    input  logic [clog2_min1(N)-1:0]    i_ptr,
    output logic                        o_valid,
    output logic [clog2_min1(N)-1:0]    o_id
);

    localparam int ID_W = clog2_min1(N);

    logic [ID_W:0]   w_sum [N];
    logic [ID_W-1:0] w_idx [N];
    logic [N-1:0]    w_rot;

    // Rotate the request vector so that position 0 is the pointer slot.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_rot
            assign w_sum[gi] = {1'b0, i_ptr} + (ID_W+1)'(gi);
            assign w_idx[gi] = (w_sum[gi] >= (ID_W+1)'(N))
                             ? ID_W'(w_sum[gi] - (ID_W+1)'(N))
                             : w_sum[gi][ID_W-1:0];
            assign w_rot[gi] = i_req[w_idx[gi]];
        end
    endgenerate

    always_comb begin
        o_valid = 1'b0;
        o_id    = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                o_valid = 1'b1;
                o_id    = w_idx[k];
            end
        end
    end

endmodule

// File: rtl/bus_arb_rr.sv
// N-requester bus arbiter with IDLE/BBUSY/BWAIT/BFREE grant FSM, round-robin selection,
// programmable turnaround interval and optional hold timeout that revokes a stuck grant.
module bus_arb_rr
    import bus_arb_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int FREE_CYCLES = 1,
    parameter int MAX_HOLD    = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    bus_arb_rr_if.master  arb_bus
);

    localparam int ID_W   = clog2_min1(N_REQ);
    localparam int HOLD_W = clog2_min1(MAX_HOLD + 1);
    localparam int FREE_W = clog2_min1(FREE_CYCLES + 1);

    // The hold timer reads MAX_HOLD-1 during the MAX_HOLD-th owned cycle.
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);
    localparam logic [FREE_W-1:0] FREE_LAST = FREE_W'(FREE_CYCLES);
    localparam logic [ID_W-1:0]   LAST_ID   = ID_W'(N_REQ - 1);

    arb_state_t        r_state, w_state_next;
    logic [ID_W-1:0]   r_owner, w_owner_next;
    logic [ID_W-1:0]   r_ptr, w_ptr_next;
    logic [HOLD_W-1:0] r_hold, w_hold_next;
    logic [FREE_W-1:0] r_free, w_free_next;
    logic              r_timeout, w_timeout_next;

    logic              w_pick_valid;
    logic [ID_W-1:0]   w_pick_id;
    logic              w_hold_expired;
    logic              w_grant;
    logic              w_busy;

    rr_pick #(
        .N (N_REQ)
    ) u_pick (
        .i_req   (arb_bus.req),
        .i_ptr   (r_ptr),
        .o_valid (w_pick_valid),
        .o_id    (w_pick_id)
    );

    assign w_hold_expired = (MAX_HOLD != 0) && (r_hold == HOLD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_owner   <= '0;
            r_ptr     <= '0;
            r_hold    <= '0;
            r_free    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_owner   <= w_owner_next;
            r_ptr     <= w_ptr_next;
            r_hold    <= w_hold_next;
            r_free    <= w_free_next;
            r_timeout <= w_timeout_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_owner_next   = r_owner;
        w_ptr_next     = r_ptr;
        w_hold_next    = r_hold;
        w_free_next    = r_free;
        w_timeout_next = 1'b0;
        w_grant        = 1'b0;

        case (r_state)
            IDLE: begin
                w_grant = w_pick_valid;
            end
            BBUSY: begin
                w_hold_next = (r_hold == '1) ? r_hold : r_hold + 1'b1;
                if (w_hold_expired) begin
                    w_state_next   = BFREE;
                    w_timeout_next = 1'b1;
                end else if (arb_bus.done) begin
                    w_state_next = arb_bus.dly ? BWAIT : BFREE;
                end
            end
            BWAIT: begin
                w_hold_next = (r_hold == '1) ? r_hold : r_hold + 1'b1;
                if (w_hold_expired) begin
                    w_state_next   = BFREE;
                    w_timeout_next = 1'b1;
                end else if (!arb_bus.dly) begin
                    w_state_next = BFREE;
                end
            end
            BFREE: begin
                if (r_free >= FREE_LAST) begin
                    w_state_next = IDLE;
                    w_grant      = w_pick_valid;
                end else begin
                    w_free_next = r_free + 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        // The free counter reads 1 during the first turnaround cycle.
        if ((w_state_next == BFREE) && (r_state != BFREE)) begin
            w_free_next = FREE_W'(1);
        end

        if (w_grant) begin
            w_state_next = BBUSY;
            w_owner_next = w_pick_id;
            w_ptr_next   = (w_pick_id == LAST_ID) ? '0 : w_pick_id + 1'b1;
            w_hold_next  = '0;
        end
    end

    assign w_busy          = (r_state == BBUSY) || (r_state == BWAIT);
    assign arb_bus.busy    = w_busy;
    assign arb_bus.gnt_id  = r_owner;
    assign arb_bus.timeout = r_timeout;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_gnt
            assign arb_bus.gnt[gi] = w_busy && (r_owner == ID_W'(gi));
        end
    endgenerate

endmodule

// File: tb/tb_bus_arb_rr.sv
// Self-checking bench for bus_arb_rr: directed protocol scenarios plus randomized traffic,
// all compared every cycle against a transaction-level model of the grant rules.
module tb_bus_arb_rr;
    import bus_arb_pkg::*;

    localparam int N    = 4;
    localparam int FREE = 2;
    localparam int MAXH = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int checks   = 0;
    int failures = 0;

    bus_arb_rr_if #(.N_REQ(N)) bus ();

    bus_arb_rr #(
        .N_REQ       (N),
        .FREE_CYCLES (FREE),
        .MAX_HOLD    (MAXH)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .arb_bus (bus)
    );

    always #5 clk = ~clk;

    // Model: who owns the bus, whether the slave asked for extra hold,
    // how many cycles the owner has held it and how many turnaround cycles remain.
    typedef struct {
        bit owned;
        bit waiting;
        int owner;
        int ptr;
        int held;
        int free_left;
        bit to;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t s;
        s.owned = 0; s.waiting = 0; s.owner = 0; s.ptr = 0;
        s.held = 0; s.free_left = 0; s.to = 0;
        return s;
    endfunction

    function automatic model_t model_step(input model_t s, input logic [N-1:0] r,
                                          input logic d, input logic y);
        model_t n;
        bit     may_grant;
        bit     found;
        int     idx;
        n = s;
        n.to = 0;
        if (s.owned) begin
            n.held = s.held + 1;
            if (n.held == MAXH) begin
                n.owned = 0; n.to = 1; n.free_left = FREE;
            end else if (!s.waiting) begin
                if (d && y) n.waiting = 1;
                else if (d) begin n.owned = 0; n.free_left = FREE; end
            end else if (!y) begin
                n.owned = 0; n.free_left = FREE;
            end
        end else begin
            may_grant = 1;
            if (s.free_left > 0) begin
                n.free_left = s.free_left - 1;
                may_grant   = (n.free_left == 0);
            end
            found = 0;
            if (may_grant) begin
                for (int k = 0; k < N; k++) begin
                    idx = (s.ptr + k) % N;
                    if (!found && r[idx]) begin
                        found     = 1;
                        n.owner   = idx;
                        n.ptr     = (idx + 1) % N;
                        n.owned   = 1;
                        n.waiting = 0;
                        n.held    = 0;
                    end
                end
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= model_reset();
        else        m <= model_step(m, bus.req, bus.done, bus.dly);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [N-1:0] eg;
        eg = m.owned ? N'(1 << m.owner) : '0;
        check("model_gnt",     32'(bus.gnt),     32'(eg));
        check("model_gnt_id",  32'(bus.gnt_id),  32'(m.owner));
        check("model_busy",    32'(bus.busy),    32'(m.owned));
        check("model_timeout", 32'(bus.timeout), 32'(m.to));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        compare_all();
        $display("cyc t=%0t req=%b done=%b dly=%b gnt=%b id=%0d busy=%b to=%b",
                 $time, bus.req, bus.done, bus.dly, bus.gnt, bus.gnt_id, bus.busy, bus.timeout);
    endtask

    task automatic wait_gnt(input string name, input int limit, output int gap);
        gap = 0;
        step();
        while (bus.gnt == '0 && gap < limit) begin
            gap++;
            step();
        end
        if (bus.gnt == '0) begin
            checks++;
            failures++;
            $display("FAIL %s no grant within %0d cycles got=0 exp=nonzero", name, limit);
        end
    endtask

    logic [N-1:0] fair_exp [5];
    int           gap;
    int           cnt;

    initial begin
        bus.req  = '0;
        bus.done = 1'b0;
        bus.dly  = 1'b0;
        fair_exp[0] = 4'b0001; fair_exp[1] = 4'b0010; fair_exp[2] = 4'b0100;
        fair_exp[3] = 4'b1000; fair_exp[4] = 4'b0001;

        #1 rst_n = 1'b0;
        #2;
        check("reset_gnt",     32'(bus.gnt),     32'd0);
        check("reset_gnt_id",  32'(bus.gnt_id),  32'd0);
        check("reset_busy",    32'(bus.busy),    32'd0);
        check("reset_timeout", 32'(bus.timeout), 32'd0);
        step();
        rst_n = 1'b1;

        // Single requester: three owned cycles, FREE turnaround cycles, then idle.
        bus.req = 4'b0001;
        step(); check("single_c1", 32'(bus.gnt), 32'h1);
        step(); check("single_c2", 32'(bus.gnt), 32'h1);
        step(); check("single_c3", 32'(bus.gnt), 32'h1);
        bus.done = 1'b1; bus.req = '0;
        step(); check("single_free1", 32'(bus.gnt), 32'h0);
        check("single_free_id", 32'(bus.gnt_id), 32'd0);
        bus.done = 1'b0;
        step(); check("single_free2", 32'(bus.gnt), 32'h0);
        step(); check("single_idle", 32'(bus.busy), 32'h0);

        // Fairness from a fresh pointer.
        rst_n = 1'b0; step(); rst_n = 1'b1;
        bus.req = 4'b1111; bus.done = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_gnt("fair_wait", 10, gap);
            check("fair_gnt", 32'(bus.gnt), 32'(fair_exp[i]));
            if (i > 0) check("fair_gap", 32'(gap), 32'(FREE));
        end
        bus.req = '0;
        step();
        bus.done = 1'b0;
        step(); step(); step();

        // Delay path: owner 2 held one BBUSY cycle plus five BWAIT cycles.
        bus.req = 4'b0100;
        step(); check("dly_first", 32'(bus.gnt), 32'h4);
        cnt = 1;
        bus.done = 1'b1; bus.dly = 1'b1; bus.req = '0;
        step(); cnt += (bus.gnt == 4'b0100) ? 1 : 0;
        check("dly_busy", 32'(bus.busy), 32'h1);
        bus.done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(); cnt += (bus.gnt == 4'b0100) ? 1 : 0;
        end
        bus.dly = 1'b0;
        step(); check("dly_release", 32'(bus.gnt), 32'h0);
        check("dly_len", 32'(cnt), 32'd6);
        step(); step();

        // Timeout: the pointer sits at 3, so requester 0 wins and is cut off after MAXH cycles.
        bus.req = 4'b0011;
        wait_gnt("to_wait", 5, gap);
        check("to_first", 32'(bus.gnt), 32'h1);
        cnt = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.gnt != 4'b0001) break;
            cnt++;
        end
        check("to_len", 32'(cnt), 32'(MAXH));
        check("to_pulse", 32'(bus.timeout), 32'h1);
        step(); check("to_pulse_end", 32'(bus.timeout), 32'h0);
        step(); check("to_next", 32'(bus.gnt), 32'h2);

        // done+dly arriving in the last allowed cycle loses to the timeout.
        for (int i = 2; i <= MAXH; i++) step();
        bus.done = 1'b1; bus.dly = 1'b1; bus.req = '0;
        step();
        check("tvd_timeout", 32'(bus.timeout), 32'h1);
        check("tvd_gnt",     32'(bus.gnt),     32'h0);
        check("tvd_busy",    32'(bus.busy),    32'h0);
        bus.done = 1'b0; bus.dly = 1'b0;
        step(); step();

        // Reset during BWAIT drops the grant at once and clears the pointer.
        bus.req = 4'b0100;
        step(); check("mrst_owner", 32'(bus.gnt), 32'h4);
        bus.done = 1'b1; bus.dly = 1'b1; bus.req = '0;
        step(); check("mrst_wait", 32'(bus.busy), 32'h1);
        bus.done = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        check("mrst_gnt",  32'(bus.gnt),    32'h0);
        check("mrst_busy", 32'(bus.busy),   32'h0);
        check("mrst_id",   32'(bus.gnt_id), 32'h0);
        step();
        rst_n = 1'b1; bus.dly = 1'b0;
        bus.req = 4'b1001;
        step(); check("mrst_ptr0", 32'(bus.gnt), 32'h1);
        bus.done = 1'b1; bus.req = 4'b1000;
        wait_gnt("mrst_wait_gnt", 6, gap);
        check("mrst_req3", 32'(bus.gnt), 32'h8);
        bus.req = '0;
        step();
        bus.done = 1'b0;
        step(); step();

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            bus.req  = 4'($urandom_range(0, 15));
            bus.done = ($urandom_range(0, 3) == 0);
            bus.dly  = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end else begin
                step();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
